bk_xfer_sequencer: RTL and testbench

//  Sequences save-state load/save transfers between the HPS SD sector channel and the system backup RAM.
//  One request moves 2**SECT_LOG2 consecutive 512-byte sectors for the selected save slot.

---
 rtl/bk_pkg.sv | 16 +
 rtl/bk_xfer_sequencer_if.sv | 12 +
 rtl/bk_edge_det.sv | 20 ++
 rtl/bk_xfer_sequencer.sv | 167 ++++++++++++++++
 tb/tb_bk_xfer_sequencer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/bk_pkg.sv
// Shared types and constants for the backup-RAM save-state transfer sequencer.
package bk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_REL,
    FINISH
  } bk_state_t;

  localparam int unsigned SECTOR_BYTES  = 512;
  localparam int unsigned SECT_LOG2_DEF = 6;
  localparam int unsigned SLOT_W_DEF    = 2;

endpackage

// File: rtl/bk_xfer_sequencer_if.sv
// SD sector channel between the sequencer (master) and hps_io (slave).
interface bk_xfer_sequencer_if;

  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;

  modport master (output sd_lba, output sd_rd, output sd_wr, input sd_ack);
  modport slave  (input sd_lba, input sd_rd, input sd_wr, output sd_ack);

endinterface

// File: rtl/bk_edge_det.sv
// Registered single-bit edge detector; FALLING selects which edge o_pulse reports.
module bk_edge_det #(
  parameter bit FALLING = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_pulse
);

  logic r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_q <= '0;
    else       r_q <= i_d;
  end

  assign o_pulse = FALLING ? (~i_d & r_q) : (i_d & ~r_q);

endmodule

// File: rtl/bk_xfer_sequencer.sv
// Save-state load/save sequencer: walks 2**SECT_LOG2 sectors of one slot over the SD channel.
// Optional ack watchdog enabled by defining BK_TIMEOUT_EN.
module bk_xfer_sequencer
  import bk_pkg::*;
#(
  parameter int unsigned SECT_LOG2  = SECT_LOG2_DEF,
  parameter int unsigned SLOT_W     = SLOT_W_DEF,
  parameter int unsigned TMO_CYCLES = 50000000
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              bk_ena,
  input  logic              load_req,
  input  logic              save_req,
  input  logic [SLOT_W-1:0] slot,
  bk_xfer_sequencer_if.master sd,
  output logic              busy,
  output logic              loading,
  output logic              done,
  output logic              error
);

  typedef logic [$clog2(TMO_CYCLES + 1)-1:0] tmo_cnt_t;

  bk_state_t            r_state,   w_state_nx;
  logic [SECT_LOG2-1:0] r_sector,  w_sector_nx;
  logic [SLOT_W-1:0]    r_slot,    w_slot_nx;
  logic                 r_dir,     w_dir_nx;
  logic [31:0]          r_lba,     w_lba_nx;
  logic                 r_rd,      w_rd_nx;
  logic                 r_wr,      w_wr_nx;
  logic                 r_busy,    w_busy_nx;
  logic                 r_loading, w_loading_nx;
  logic                 r_done,    w_done_nx;
  logic                 r_err,     w_err_nx;

  logic w_load_rise, w_save_rise, w_ack_rise, w_ack_fall, w_tmo;

  // Requests are gated by bk_ena before edge detection, so history tracks req & bk_ena.
  bk_edge_det #(.FALLING(1'b0)) u_load_det (
    .i_clk(clk_sys), .i_rst(reset), .i_d(load_req & bk_ena), .o_pulse(w_load_rise));
  bk_edge_det #(.FALLING(1'b0)) u_save_det (
    .i_clk(clk_sys), .i_rst(reset), .i_d(save_req & bk_ena), .o_pulse(w_save_rise));
  bk_edge_det #(.FALLING(1'b0)) u_ack_rise (
    .i_clk(clk_sys), .i_rst(reset), .i_d(sd.sd_ack), .o_pulse(w_ack_rise));
  bk_edge_det #(.FALLING(1'b1)) u_ack_fall (
    .i_clk(clk_sys), .i_rst(reset), .i_d(sd.sd_ack), .o_pulse(w_ack_fall));

`ifdef BK_TIMEOUT_EN
  tmo_cnt_t r_tmo;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                                         r_tmo <= '0;
    else if (r_state == ISSUE)                         r_tmo <= '0;
    else if (r_state == WAIT_ACK || r_state == WAIT_REL) r_tmo <= r_tmo + tmo_cnt_t'(1);
  end

  assign w_tmo = (r_state == WAIT_ACK || r_state == WAIT_REL) &&
                 (r_tmo == tmo_cnt_t'(TMO_CYCLES - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_state_nx   = r_state;
    w_sector_nx  = r_sector;
    w_slot_nx    = r_slot;
    w_dir_nx     = r_dir;
    w_lba_nx     = r_lba;
    w_rd_nx      = r_rd;
    w_wr_nx      = r_wr;
    w_busy_nx    = r_busy;
    w_loading_nx = r_loading;
    w_done_nx    = 1'b0;
    w_err_nx     = r_err;

    case (r_state)
      IDLE: begin
        if (w_load_rise || w_save_rise) begin
          w_slot_nx    = slot;
          w_dir_nx     = w_load_rise;
          w_sector_nx  = '0;
          w_err_nx     = 1'b0;
          w_busy_nx    = 1'b1;
          w_loading_nx = w_load_rise;
          w_state_nx   = ISSUE;
        end
      end
      ISSUE: begin
        w_lba_nx   = 32'({r_slot, r_sector});
        w_rd_nx    = r_dir;
        w_wr_nx    = ~r_dir;
        w_state_nx = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (w_ack_rise) begin
          w_rd_nx    = 1'b0;
          w_wr_nx    = 1'b0;
          w_state_nx = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (w_ack_fall) begin
          if (&r_sector) begin
            w_busy_nx    = 1'b0;
            w_loading_nx = 1'b0;
            w_done_nx    = 1'b1;
            w_state_nx   = FINISH;
          end else begin
            w_sector_nx = r_sector + SECT_LOG2'(1);
            w_state_nx  = ISSUE;
          end
        end
      end
      FINISH: w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase

    // Watchdog abort overrides any ack handling in the wait states.
    if (w_tmo) begin
      w_rd_nx      = 1'b0;
      w_wr_nx      = 1'b0;
      w_err_nx     = 1'b1;
      w_busy_nx    = 1'b0;
      w_loading_nx = 1'b0;
      w_done_nx    = 1'b1;
      w_state_nx   = FINISH;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_sector  <= '0;
      r_slot    <= '0;
      r_dir     <= 1'b0;
      r_lba     <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_busy    <= 1'b0;
      r_loading <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_sector  <= w_sector_nx;
      r_slot    <= w_slot_nx;
      r_dir     <= w_dir_nx;
      r_lba     <= w_lba_nx;
      r_rd      <= w_rd_nx;
      r_wr      <= w_wr_nx;
      r_busy    <= w_busy_nx;
      r_loading <= w_loading_nx;
      r_done    <= w_done_nx;
      r_err     <= w_err_nx;
    end
  end

  assign sd.sd_lba = r_lba;
  assign sd.sd_rd  = r_rd;
  assign sd.sd_wr  = r_wr;
  assign busy      = r_busy;
  assign loading   = r_loading;
  assign done      = r_done;
  assign error     = r_err;

endmodule

// File: tb/tb_bk_xfer_sequencer.sv
// Directed self-checking bench for bk_xfer_sequencer with a delayed-ack hps_io model.
module tb_bk_xfer_sequencer;

  logic       clk_sys  = 1'b0;
  logic       reset    = 1'b1;
  logic       bk_ena   = 1'b0;
  logic       load_req = 1'b0;
  logic       save_req = 1'b0;
  logic [1:0] slot     = '0;
  logic       busy, loading, done, error;

  bk_xfer_sequencer_if sd_if ();

  bk_xfer_sequencer #(
    .SECT_LOG2 (6),
    .SLOT_W    (2),
    .TMO_CYCLES(100)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bk_ena  (bk_ena),
    .load_req(load_req),
    .save_req(save_req),
    .slot    (slot),
    .sd      (sd_if),
    .busy    (busy),
    .loading (loading),
    .done    (done),
    .error   (error)
  );

  always #5 clk_sys = ~clk_sys;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // hps_io ack model: 3 cycles after a request, ack high for 4 cycles
  bit ack_en = 1'b1;
  initial begin
    sd_if.sd_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (ack_en && !reset && (sd_if.sd_rd || sd_if.sd_wr)) begin
        repeat (3) @(negedge clk_sys);
        sd_if.sd_ack = 1'b1;
        repeat (4) @(negedge clk_sys);
        sd_if.sd_ack = 1'b0;
      end
    end
  end

  // Monitor: request pulses, LBA sequence, exclusivity and done pulses
  int unsigned n_rd = 0, n_wr = 0, n_done = 0;
  logic [31:0] exp_base = '0;
  logic prev_rd = 1'b0, prev_wr = 1'b0, prev_busy = 1'b0;

  always @(negedge clk_sys) begin
    if (sd_if.sd_rd && sd_if.sd_wr) check("rd_wr_excl", 32'(sd_if.sd_rd & sd_if.sd_wr), 32'd0);
    if (sd_if.sd_rd && !prev_rd) begin
      check("rd_lba", sd_if.sd_lba, exp_base + n_rd);
      check("rd_loading", 32'(loading), 32'd1);
      n_rd++;
    end
    if (sd_if.sd_wr && !prev_wr) begin
      check("wr_lba", sd_if.sd_lba, exp_base + n_wr);
      check("wr_loading", 32'(loading), 32'd0);
      n_wr++;
    end
    if (done) begin
      n_done++;
      check("done_busy", 32'(busy), 32'd0);
      check("done_loading", 32'(loading), 32'd0);
      check("done_prev_busy", 32'(prev_busy), 32'd1);
    end
    prev_rd   = sd_if.sd_rd;
    prev_wr   = sd_if.sd_wr;
    prev_busy = busy;
  end

  task automatic tick;
    @(negedge clk_sys);
    #1;
  endtask

  task automatic clr(input logic [31:0] base);
    n_rd = 0; n_wr = 0; n_done = 0; exp_base = base;
  endtask

  task automatic wait_done(input string tag);
    int unsigned k = 0;
    while (!done && k < 2000) begin tick(); k++; end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_rd(input string tag, input int unsigned n);
    int unsigned k = 0;
    while (n_rd < n && k < 2000) begin tick(); k++; end
    check(tag, n_rd, n);
  endtask

  initial begin
    int unsigned k;
    repeat (3) tick();
    check("rst_rd", 32'(sd_if.sd_rd), 32'd0);
    check("rst_wr", 32'(sd_if.sd_wr), 32'd0);
    check("rst_lba", sd_if.sd_lba, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_loading", 32'(loading), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    bk_ena = 1'b1;
    tick();

    // 1: save slot 2, LBA 0x80..0xBF, 2-cycle request latency
    clr(32'h80); slot = 2'd2; tick();
    save_req = 1'b1; tick();
    check("t1_lat1_wr", 32'(sd_if.sd_wr), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    slot = 2'd0;
    tick();
    check("t1_lat2_wr", 32'(sd_if.sd_wr), 32'd1);
    check("t1_lat2_lba", sd_if.sd_lba, 32'h80);
    wait_done("t1_done");
    check("t1_wr_at_done", n_wr, 32'd64);
    tick();
    check("t1_rd_cnt", n_rd, 32'd0);
    check("t1_done_cnt", n_done, 32'd1);
    save_req = 1'b0;

    // 2: load slot 1, LBA 0x40..0x7F
    clr(32'h40); slot = 2'd1; tick();
    load_req = 1'b1;
    wait_done("t2_done");
    check("t2_rd_at_done", n_rd, 32'd64);
    tick();
    check("t2_wr_cnt", n_wr, 32'd0);
    check("t2_done_cnt", n_done, 32'd1);
    load_req = 1'b0;

    // 3: simultaneous rises, load wins; held save_req does not retrigger
    clr(32'h00); slot = 2'd0; tick();
    load_req = 1'b1; save_req = 1'b1;
    wait_done("t3_done");
    check("t3_rd_cnt", n_rd, 32'd64);
    repeat (20) tick();
    check("t3_busy_after", 32'(busy), 32'd0);
    check("t3_wr_cnt", n_wr, 32'd0);
    check("t3_done_cnt", n_done, 32'd1);
    load_req = 1'b0; save_req = 1'b0; tick();

    // 4a: save request while bk_ena low is ignored
    bk_ena = 1'b0; clr(32'h00); tick();
    save_req = 1'b1;
    repeat (20) tick();
    check("t4_busy_dis", 32'(busy), 32'd0);
    check("t4_wr_dis", n_wr, 32'd0);
    save_req = 1'b0; tick();
    bk_ena = 1'b1; tick();

    // 4b: bk_ena drops at sector 10 of a load, transfer still completes
    clr(32'hC0); slot = 2'd3; tick();
    load_req = 1'b1;
    wait_rd("t4_reach10", 11);
    bk_ena = 1'b0;
    wait_done("t4_done");
    check("t4_rd_cnt", n_rd, 32'd64);
    load_req = 1'b0; tick();
    bk_ena = 1'b1; tick();

    // 5: reset at sector 30 while sd_rd high, then restart from sector 0
    clr(32'h00); slot = 2'd0; tick();
    load_req = 1'b1;
    wait_rd("t5_reach30", 31);
    check("t5_rd_before", 32'(sd_if.sd_rd), 32'd1);
    reset = 1'b1; load_req = 1'b0;
    #1;
    check("t5_rd_rst", 32'(sd_if.sd_rd), 32'd0);
    check("t5_busy_rst", 32'(busy), 32'd0);
    check("t5_loading_rst", 32'(loading), 32'd0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (15) tick();
    check("t5_no_done", n_done, 32'd0);
    check("t5_idle_busy", 32'(busy), 32'd0);
    clr(32'h00); tick();
    load_req = 1'b1;
    wait_done("t5_restart_done");
    check("t5_restart_cnt", n_rd, 32'd64);
    load_req = 1'b0; tick();

`ifdef BK_TIMEOUT_EN
    // 6: ack never rises, watchdog aborts after 100 cycles
    ack_en = 1'b0;
    clr(32'h40); slot = 2'd1; tick();
    load_req = 1'b1;
    wait_rd("t6_issue", 1);
    k = 0;
    while (sd_if.sd_rd && k < 300) begin tick(); k++; end
    check("t6_rd_len", k, 32'd100);
    check("t6_error", 32'(error), 32'd1);
    wait_done("t6_done");
    ack_en = 1'b1; load_req = 1'b0; tick();
    load_req = 1'b1; tick();
    check("t6_error_clr", 32'(error), 32'd0);
    wait_done("t6_retry_done");
    check("t6_error_after", 32'(error), 32'd0);
    load_req = 1'b0; tick();
`else
    check("err_tied", 32'(error), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
